// File: rtl/seq_stream_ctrl.sv
// Stimulus sequencer for the serial sequence detector: latches a word and streams it MSB-first
// with a divided step clock, counting detector matches sampled once per bit.
module seq_stream_ctrl #(
  parameter int P_WORD_W = 16,
  parameter int P_LEN_W  = 5,
  parameter int P_HALF   = 25_000_000,
  parameter int P_CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [P_WORD_W-1:0] word_in,
  input  logic [P_LEN_W-1:0]  len_in,
  input  logic                det_equal,
  output logic                seq_out,
  output logic                seq_clk,
  output logic                busy,
  output logic                done,
  output logic [P_CNT_W-1:0]  match_cnt
);

  localparam int                 LP_HC_W      = (P_HALF > 1) ? $clog2(P_HALF) : 1;
  localparam logic [LP_HC_W-1:0] LP_HALF_LAST = LP_HC_W'(P_HALF - 1);
  localparam logic [P_LEN_W-1:0] LP_MAX_LEN   = P_LEN_W'(P_WORD_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [P_WORD_W-1:0]   r_shift;
  logic [P_LEN_W-1:0]    r_len;
  logic [P_LEN_W-1:0]    r_bits_left;
  logic [LP_HC_W-1:0]    r_half_cnt;
  logic                  r_seq_out;
  logic                  r_seq_clk;
  logic                  r_busy;
  logic                  r_done;
  logic [P_CNT_W-1:0]    r_match_cnt;

  logic [P_LEN_W-1:0]    w_len;
  logic [P_WORD_W-1:0]   w_aligned;
  logic                  w_abort_act;

  always_comb begin
    w_len = len_in;
    if (len_in == '0 || len_in > LP_MAX_LEN) w_len = LP_MAX_LEN;
  end

  // Left-align the word so the next bit to send is always the shadow register MSB.
  assign w_aligned   = word_in << (LP_MAX_LEN - w_len);
  assign w_abort_act = abort && (r_state == S_LOAD || r_state == S_SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_len       <= '0;
      r_bits_left <= '0;
      r_half_cnt  <= '0;
      r_seq_out   <= 1'b0;
      r_seq_clk   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_match_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_abort_act) begin
        r_state    <= S_IDLE;
        r_seq_clk  <= 1'b0;
        r_busy     <= 1'b0;
        r_half_cnt <= '0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (start && !abort) begin
              r_shift     <= w_aligned;
              r_len       <= w_len;
              r_match_cnt <= '0;
              r_busy      <= 1'b1;
              r_state     <= S_LOAD;
            end
          end
          S_LOAD: begin
            r_seq_out   <= r_shift[P_WORD_W-1];
            r_shift     <= r_shift << 1;
            r_bits_left <= r_len;
            r_seq_clk   <= 1'b0;
            r_half_cnt  <= '0;
            r_state     <= S_SHIFT;
          end
          S_SHIFT: begin
            if (r_half_cnt == LP_HALF_LAST) begin
              r_half_cnt <= '0;
              r_seq_clk  <= ~r_seq_clk;
              if (!r_seq_clk) begin
                // Rising step: det_equal still reflects the detector's pre-edge state.
                if (det_equal && r_match_cnt != '1) r_match_cnt <= r_match_cnt + 1'b1;
              end else begin
                r_bits_left <= r_bits_left - 1'b1;
                if (r_bits_left == P_LEN_W'(1)) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                end else begin
                  r_seq_out <= r_shift[P_WORD_W-1];
                  r_shift   <= r_shift << 1;
                end
              end
            end else begin
              r_half_cnt <= r_half_cnt + 1'b1;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign seq_out   = r_seq_out;
  assign seq_clk   = r_seq_clk;
  assign busy      = r_busy;
  assign done      = r_done;
  assign match_cnt = r_match_cnt;

endmodule
